// File: rtl/fp_minmax_cmp_pipe.sv
// Pipelined IEEE-754 min/max and compare unit with RISC-V NaN / signed-zero semantics.
// The result is computed combinationally at the input and carried through an elastic valid/ready pipe.

module fp_minmax_cmp_slot #(
  parameter int PW = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          vld_i,
  input  logic [PW-1:0] dat_i,
  input  logic          rdy_nxt_i,
  output logic          vld_o,
  output logic [PW-1:0] dat_o,
  output logic          rdy_o
);
  logic          vld_q, vld_d;
  logic [PW-1:0] dat_q, dat_d;

  // A slot can take a new beat when empty or when its current beat leaves this cycle.
  assign rdy_o = ~vld_q | rdy_nxt_i;
  assign vld_o = vld_q;
  assign dat_o = dat_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (rdy_o) begin
      vld_d = vld_i;
      if (vld_i) dat_d = dat_i;
    end
    if (flush_i) vld_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end
endmodule

module fp_minmax_cmp_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       op_i,
  input  logic [W-1:0]     rs1_i,
  input  logic [W-1:0]     rs2_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W-1:0]     rd_o,
  output logic             nv_o,
  output logic [TAG_W-1:0] tag_o
);
  typedef enum logic [2:0] {
    OP_FMIN = 3'd0,
    OP_FMAX = 3'd1,
    OP_FEQ  = 3'd2,
    OP_FLT  = 3'd3,
    OP_FLE  = 3'd4
  } op_e;

  typedef struct packed {
    logic [W-1:0]     rd;
    logic             nv;
    logic [TAG_W-1:0] tag;
  } res_t;

  localparam int PW = $bits(res_t);
  localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic sa, sb, nan_a, nan_b, snan_a, snan_b, any_nan, any_snan;
  logic mag_lt_ab, mag_lt_ba, lt_ab, lt_ba, both_zero, feq, flt;
  res_t res;

  always_comb begin
    sa        = rs1_i[W-1];
    sb        = rs2_i[W-1];
    nan_a     = (&rs1_i[W-2:MAN_W]) & (|rs1_i[MAN_W-1:0]);
    nan_b     = (&rs2_i[W-2:MAN_W]) & (|rs2_i[MAN_W-1:0]);
    snan_a    = nan_a & ~rs1_i[MAN_W-1];
    snan_b    = nan_b & ~rs2_i[MAN_W-1];
    any_nan   = nan_a | nan_b;
    any_snan  = snan_a | snan_b;
    mag_lt_ab = rs1_i[W-2:0] < rs2_i[W-2:0];
    mag_lt_ba = rs2_i[W-2:0] < rs1_i[W-2:0];
    // Sign-magnitude total order: differing signs decide outright, so -0 < +0 here.
    lt_ab     = (sa != sb) ? sa : (sa ? mag_lt_ba : mag_lt_ab);
    lt_ba     = (sa != sb) ? sb : (sa ? mag_lt_ab : mag_lt_ba);
    both_zero = ~(|rs1_i[W-2:0]) & ~(|rs2_i[W-2:0]);
    feq       = (rs1_i == rs2_i) | both_zero;
    flt       = lt_ab & ~both_zero;

    res     = '0;
    res.tag = tag_i;
    case (op_i)
      OP_FMIN, OP_FMAX: begin
        res.nv = any_snan;
        if (nan_a & nan_b)      res.rd = CANON_NAN;
        else if (nan_a)         res.rd = rs2_i;
        else if (nan_b)         res.rd = rs1_i;
        else if (op_i == OP_FMIN) res.rd = lt_ba ? rs2_i : rs1_i;
        else                    res.rd = lt_ab ? rs2_i : rs1_i;
      end
      OP_FEQ: begin
        res.nv    = any_snan;
        res.rd[0] = ~any_nan & feq;
      end
      OP_FLT: begin
        res.nv    = any_nan;
        res.rd[0] = ~any_nan & flt;
      end
      OP_FLE: begin
        res.nv    = any_nan;
        res.rd[0] = ~any_nan & (flt | feq);
      end
      default: ;
    endcase
  end

  // Index 0 is the input beat; index s+1 is the output of slot s.
  logic [STAGES:0]         vld_pipe;
  logic [STAGES:0]         rdy_pipe;
  logic [STAGES:0][PW-1:0] dat_pipe;
  res_t                    out_res;

  assign vld_pipe[0]      = in_valid_i;
  assign dat_pipe[0]      = res;
  assign rdy_pipe[STAGES] = out_ready_i;

  for (genvar s = 0; s < STAGES; s++) begin : g_slot
    fp_minmax_cmp_slot #(.PW(PW)) u_slot (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .flush_i  (flush_i),
      .vld_i    (vld_pipe[s]),
      .dat_i    (dat_pipe[s]),
      .rdy_nxt_i(rdy_pipe[s+1]),
      .vld_o    (vld_pipe[s+1]),
      .dat_o    (dat_pipe[s+1]),
      .rdy_o    (rdy_pipe[s])
    );
  end

  assign out_res     = dat_pipe[STAGES];
  assign in_ready_o  = rdy_pipe[0];
  assign out_valid_o = vld_pipe[STAGES];
  assign rd_o        = out_res.rd;
  assign nv_o        = out_res.nv;
  assign tag_o       = out_res.tag;
endmodule

// File: tb/tb_fp_minmax_cmp_pipe.sv
// Directed + random bench for fp_minmax_cmp_pipe: scoreboard queue filled on accept, drained on emit.
module tb_fp_minmax_cmp_pipe;
  localparam int W = 32;
  localparam int STAGES = 3;

  typedef struct packed {
    logic [W-1:0] rd;
    logic         nv;
    logic [3:0]   tag;
  } exp_t;

  logic         clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, nv;
  logic [2:0]   op = '0;
  logic [W-1:0] rs1 = '0, rs2 = '0, rd;
  logic [3:0]   tag_in = '0, tag_out;

  int checks = 0, errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  fp_minmax_cmp_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(STAGES), .TAG_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .op_i(op),
    .rs1_i(rs1), .rs2_i(rs2), .tag_i(tag_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .rd_o(rd), .nv_o(nv), .tag_o(tag_out)
  );

  task automatic chk(input string nm, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", nm, obs, exp);
    end
  endtask

  // Ordering key: maps sign-magnitude onto unsigned order (-0 just below +0).
  function automatic logic [W-1:0] okey(input logic [W-1:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] t);
    exp_t m;
    logic an, bn, asn, bsn, bz;
    an  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    asn = an && !a[22];
    bsn = bn && !b[22];
    bz  = (a[30:0] == 0) && (b[30:0] == 0);
    m = '0;
    m.tag = t;
    case (o)
      3'd0, 3'd1: begin
        m.nv = asn | bsn;
        if (an && bn)   m.rd = 32'h7FC0_0000;
        else if (an)    m.rd = b;
        else if (bn)    m.rd = a;
        else if (o == 3'd0) m.rd = (okey(b) < okey(a)) ? b : a;
        else            m.rd = (okey(b) > okey(a)) ? b : a;
      end
      3'd2: begin m.nv = asn | bsn; m.rd[0] = !an && !bn && (a == b || bz); end
      3'd3: begin m.nv = an | bn;   m.rd[0] = !an && !bn && okey(a) < okey(b) && !bz; end
      3'd4: begin m.nv = an | bn;   m.rd[0] = !an && !bn && (okey(a) < okey(b) || a == b || bz); end
      default: ;
    endcase
    return m;
  endfunction

  // Present one beat until accepted; the expected result enters the scoreboard on the accepting edge.
  task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [3:0] t, input logic [W-1:0] erd, input logic env);
    logic ok = 1'b0;
    exp_t e;
    in_valid = 1'b1; op = o; rs1 = a; rs2 = b; tag_in = t;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
    end
    if (ok) begin
      e.rd = erd; e.nv = env; e.tag = t;
      q.push_back(e);
    end else begin
      checks++; errors++;
      $display("FAIL accept_timeout: tag %0d not accepted within 50 cycles", t);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] t);
    exp_t m = model(o, a, b, t);
    send(o, a, b, t, m.rd, m.nv);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && q.size() != 0; k++) @(negedge clk);
    chk("drain_empty", W'(q.size()), '0);
  endtask

  // Emit monitor: inputs only change just after posedge, so negedge sees the handshake of the next edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL emit_unexpected: got tag %h rd %h expected no output", tag_out, rd);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("emit_rd", rd, e.rd);
        chk("emit_nv", W'(nv), W'(e.nv));
        chk("emit_tag", W'(tag_out), W'(e.tag));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] vals[11];
    logic [W-1:0] h_rd;
    logic [3:0]   h_tag;
    logic         h_nv;
    int n;
    vals = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hC000_0000, 32'h7FC0_0000,
             32'h7F80_0001, 32'hFF80_0000, 32'h7F80_0000, 32'hBF80_0000, 32'h0000_0001,
             32'h3F80_0001};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rst_in_ready", W'(in_ready), 1);
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_rd", rd, 0);
    chk("rst_nv", W'(nv), 0);
    chk("rst_tag", W'(tag_out), 0);
    @(posedge clk); #1;

    // Latency and basic min/max
    send(3'd0, 32'h3F80_0000, 32'hC000_0000, 4'd1, 32'hC000_0000, 1'b0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      n++;
    end
    chk("latency", W'(n + 1), W'(STAGES));
    @(posedge clk); #1;
    send(3'd1, 32'h3F80_0000, 32'hC000_0000, 4'd2, 32'h3F80_0000, 1'b0);

    // Signed zeros
    send(3'd0, 32'h0000_0000, 32'h8000_0000, 4'd3, 32'h8000_0000, 1'b0);
    send(3'd1, 32'h0000_0000, 32'h8000_0000, 4'd4, 32'h0000_0000, 1'b0);
    send(3'd2, 32'h0000_0000, 32'h8000_0000, 4'd5, 32'h1, 1'b0);
    send(3'd3, 32'h0000_0000, 32'h8000_0000, 4'd6, 32'h0, 1'b0);

    // NaN handling and illegal op
    send(3'd1, 32'h7FC0_0000, 32'h3F80_0000, 4'd7, 32'h3F80_0000, 1'b0);
    send(3'd0, 32'h7F80_0001, 32'h7FC0_0000, 4'd8, 32'h7FC0_0000, 1'b1);
    send(3'd2, 32'h7FC0_0000, 32'h3F80_0000, 4'd9, 32'h0, 1'b0);
    send(3'd4, 32'h7FC0_0000, 32'h3F80_0000, 4'd10, 32'h0, 1'b1);
    send(3'd6, 32'h7F80_0001, 32'h3F80_0000, 4'd11, 32'h0, 1'b0);
    send(3'd4, 32'hC000_0000, 32'hC000_0000, 4'd12, 32'h1, 1'b0);
    drain();

    // Backpressure: three beats fill the pipe, outputs must hold still
    @(posedge clk); #1 out_ready = 1'b0;
    for (int t = 0; t < 3; t++) send_m(3'(t % 5), vals[t + 2], vals[t + 3], 4'(t));
    @(negedge clk);
    chk("bp_in_ready_low", W'(in_ready), 0);
    chk("bp_out_valid", W'(out_valid), 1);
    h_rd = rd; h_tag = tag_out; h_nv = nv;
    repeat (5) begin
      @(negedge clk);
      chk("bp_stable_rd", rd, h_rd);
      chk("bp_stable_nv", W'(nv), W'(h_nv));
      chk("bp_stable_tag", W'(tag_out), W'(h_tag));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    for (int t = 3; t < 6; t++) send_m(3'(t % 5), vals[t + 2], vals[t + 3], 4'(t));
    drain();

    // Flush with two in flight and one presented
    @(posedge clk); #1;
    send_m(3'd0, vals[2], vals[3], 4'd13);
    send_m(3'd1, vals[2], vals[3], 4'd14);
    in_valid = 1'b1; op = 3'd2; rs1 = vals[0]; rs2 = vals[1]; tag_in = 4'd15; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    q.delete();
    repeat (STAGES + 1) begin
      @(negedge clk);
      chk("flush_out_valid", W'(out_valid), 0);
    end
    @(posedge clk); #1;
    send(3'd3, 32'hC000_0000, 32'h3F80_0000, 4'd6, 32'h1, 1'b0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      n++;
    end
    chk("flush_next_latency", W'(n + 1), W'(STAGES));
    drain();

    // Random mix including illegal ops
    @(posedge clk); #1;
    for (int i = 0; i < 24; i++)
      send_m(3'($urandom_range(0, 7)), vals[$urandom_range(0, 10)], vals[$urandom_range(0, 10)],
             4'($urandom_range(0, 15)));
    drain();

    // Asynchronous reset while results are held
    @(posedge clk); #1 out_ready = 1'b0;
    send(3'd0, 32'h7F80_0001, 32'h3F80_0000, 4'd10, 32'h3F80_0000, 1'b1);
    send(3'd1, 32'h3F80_0000, 32'hC000_0000, 4'd11, 32'h3F80_0000, 1'b0);
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    chk("pre_rst_out_valid", W'(out_valid), 1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", W'(out_valid), 0);
    chk("async_rst_rd", rd, 0);
    chk("async_rst_nv", W'(nv), 0);
    chk("async_rst_tag", W'(tag_out), 0);
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("post_rst_in_ready", W'(in_ready), 1);
    @(posedge clk); #1 out_ready = 1'b1;
    send(3'd1, 32'hBF80_0000, 32'hC000_0000, 4'd5, 32'hBF80_0000, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
